uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clock cycles per bit (100 MHz clk, 9600 baud); legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; value is fixed at 4 (2-bit pointers).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  FIFO write request, sampled on rising clk.
REQ-006 SHALL have port din  input  8  byte to enqueue when wr_en is accepted.
REQ-007 SHALL have port full  output  1  FIFO holds 4 bytes.
REQ-008 SHALL have port empty  output  1  FIFO holds 0 bytes.
REQ-009 SHALL have port TX  output  1  serial line, registered, idle high.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 SHALL accept a write when wr_en=1 and full=0 before the edge; the write occurs even if a pop happens on the same edge.
REQ-013 SHALL drop a write when full=1 before the edge, even if a pop happens on the same edge; FIFO contents are unchanged.
REQ-014 SHALL leave the count unchanged on a simultaneous accepted write and pop.
REQ-015 SHALL wrap read/write pointers modulo 4 and keep a 3-bit count, 0..4.
REQ-016 SHALL derive full (count==4) and empty (count==0) from the registered count, with no combinational path from wr_en.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-018 IDLE: TX=1; if empty=0, pop the head into an 8-bit shift register, set TX=0 and enter START on that same edge.
REQ-019 Latency: a write accepted at edge k into an empty idle block SHALL drive TX low after edge k+1.
REQ-020 START: TX SHALL stay 0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-021 DATA: SHALL send 8 bits LSB first, each held exactly CLKS_PER_BIT cycles; a 3-bit index counts 0..7, then go to STOP.
REQ-022 STOP: TX=1 for exactly CLKS_PER_BIT cycles.
REQ-023 At the last STOP cycle, SHALL pulse done for one cycle.
REQ-024 At the last STOP cycle, if empty=0, SHALL pop the next byte and enter START directly, giving back-to-back frames with no idle cycles.
REQ-025 At the last STOP cycle, if empty=1, SHALL return to IDLE.
REQ-026 SHALL use a baud counter counting 0..CLKS_PER_BIT-1, cleared on every bit transition; frame length is exactly 10*CLKS_PER_BIT cycles.
REQ-027 SHALL accept writes during any state without disturbing the frame in flight.
REQ-028 SHALL keep busy=1 continuously across back-to-back frames.

Reset
REQ-029 While reset=0, SHALL immediately set TX=1, busy=0, done=0, empty=1, full=0, FSM=IDLE, pointers/count/baud counter/bit index to 0, and shift register to 0x00.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard all queued bytes; no partial frame resumes after release.
REQ-031 After reset release, SHALL keep TX high until the first accepted write.

Verification
REQ-032 Single byte 0x4C written while idle -> TX: 0 | 0,0,1,1,0,0,1,0 | 1, each 10416 cycles; one done pulse at cycle 104160 after TX falls; then busy=0 and empty=1.
REQ-033 Bytes 0x31, 0x4C, 0x35 written on three consecutive cycles -> three contiguous frames, no high gap between stop and next start, busy high throughout, exactly three done pulses.
REQ-034 Six writes on consecutive cycles from idle (0x01..0x06) -> first pops on the 2nd write edge, full=1 after the 5th write, 0x06 dropped, and 0x01..0x05 transmitted in order.
REQ-035 Reset pulsed low during data bit 3 of 0x4C with 2 bytes queued -> TX=1, busy=0, empty=1 asynchronously; no TX activity after release until a new write.
REQ-036 CLKS_PER_BIT=4, byte 0xA5 -> frame lasts 40 cycles with bits 1,0,1,0,0,1,0,1 after the start bit, and done on cycle 40.

Source files
------------

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Purpose : 8N1 UART transmitter with a 4-entry transmit FIFO. Bytes written
//           through wr_en/din are queued and sent LSB first, framed by one
//           start bit (low) and one stop bit (high). When the FIFO still holds
//           data at the end of a stop bit, the next frame starts on the very
//           next cycle, so streamed bytes go out back-to-back.
// Ports   : clk    - system clock, all state changes on its rising edge
//           reset  - asynchronous, active-low reset
//           wr_en  - FIFO write request
//           din    - byte to enqueue when the write is accepted
//           full   - FIFO holds 4 bytes (writes are dropped)
//           empty  - FIFO holds 0 bytes
//           TX     - registered serial line, idle high
//           busy   - transmitter is in the middle of a frame
//           done   - one-cycle pulse during the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] din,
   output logic       full,
   output logic       empty,
   output logic       TX,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       FULL_COUNT = 3'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [7:0]       r_mem [4];
   logic [1:0]       r_wrPtr;
   logic [1:0]       r_rdPtr;
   logic [2:0]       r_count;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_baudCnt;
   logic [2:0]       r_bitIdx;
   logic [7:0]       r_shift;
   logic             r_tx;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic             w_bitEnd;
   logic [7:0]       w_head;

   assign w_full   = (r_count == FULL_COUNT);
   assign w_empty  = (r_count == 3'd0);
   assign w_push   = wr_en && !w_full;
   assign w_bitEnd = (r_baudCnt == BAUD_LAST);
   assign w_head   = r_mem[r_rdPtr];

   // The FSM takes a byte either straight from idle or at the final stop
   // cycle, which is what makes back-to-back frames gap-free.
   assign w_pop = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bitEnd));

   assign full  = w_full;
   assign empty = w_empty;
   assign TX    = r_tx;
   assign busy  = (r_state != IDLE);
   assign done  = (r_state == STOP) && w_bitEnd;

   // Storage array needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   // Pointers wrap naturally at 4. The write decision uses the count from
   // before the edge, so a pop on the same edge cannot rescue a write to a
   // full FIFO, and a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= 2'd0;
         r_rdPtr <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 2'd1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Frame sequencer. TX is driven from a register one edge ahead of each
   // bit, so every bit value is set on the same edge that starts its period.
   // The shift register is shifted only between data bits; r_shift[0] is
   // always the bit currently on the line during DATA.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_baudCnt <= '0;
         r_bitIdx  <= 3'd0;
         r_shift   <= 8'h00;
         r_tx      <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_baudCnt <= '0;
               r_bitIdx  <= 3'd0;
               r_tx      <= 1'b1;
               if (w_pop) begin
                  r_shift <= w_head;
                  r_tx    <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  r_tx      <= r_shift[0];
                  r_state   <= DATA;
               end else begin
                  r_baudCnt <= r_baudCnt + CNT_W'(1);
               end
            end
            DATA: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  if (r_bitIdx == 3'd7) begin
                     r_bitIdx <= 3'd0;
                     r_tx     <= 1'b1;
                     r_state  <= STOP;
                  end else begin
                     r_bitIdx <= r_bitIdx + 3'd1;
                     r_shift  <= {1'b0, r_shift[7:1]};
                     r_tx     <= r_shift[1];
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + CNT_W'(1);
               end
            end
            STOP: begin
               if (w_bitEnd) begin
                  r_baudCnt <= '0;
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_tx    <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= IDLE;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule
